// File: rtl/envelope_cordic.sv
// -----------------------------------------------------------------------------
// envelope_cordic
// Envelope (magnitude) detector for the AM receiver back end. Each accepted
// I/Q pair (signed Q32.32) is vectored onto the positive x axis by an
// iterative CORDIC engine (one micro-rotation per clock). The CORDIC gain is
// then removed by multiplying with 1/K, giving sqrt(c^2 + s^2) in Q32.32.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous reset, active low (0 = reset)
//   in_valid   in   I/Q pair present on in_c/in_s
//   in_ready   out  pair accepted this cycle (IDLE only, from state alone)
//   in_c       in   in-phase sample, signed Q32.32
//   in_s       in   quadrature sample, signed Q32.32
//   out_mag    out  envelope, Q32.32, >= 0, holds the last result
//   out_valid  out  one-cycle pulse when out_mag has just been updated
//   busy       out  high in every state except IDLE
// -----------------------------------------------------------------------------
module envelope_cordic #(
   parameter int WIDTH = 64,
   parameter int FRAC  = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_c,
   input  logic [WIDTH-1:0] in_s,
   output logic [WIDTH-1:0] out_mag,
   output logic             out_valid,
   output logic             busy
);

   // Two guard bits: abs(-2^(WIDTH-1)) plus the sqrt(2)*1.647 CORDIC growth.
   localparam int XW = WIDTH + 2;
   localparam int IW = $clog2(ITER) + 1;
   localparam int PW = XW + 33;
   // 1/K = 0.607252935 * 2^32, used as an unsigned 33-bit operand.
   localparam logic [32:0] KINV = 33'h0_9B74_EDA8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ROT,
      S_SCALE,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic        [IW-1:0]   i_q, i_d;
   logic signed [XW-1:0]   x_q, x_d;
   logic signed [XW-1:0]   y_q, y_d;
   logic        [WIDTH-1:0] mag_q, mag_d;
   logic signed [PW-1:0]   x_ext, k_ext, prod;

   // Drop the fraction of the gain-compensated product and bound the result
   // to the non-negative WIDTH-bit range.
   function automatic logic [WIDTH-1:0] sat_mag(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      logic signed [PW-1:0] r_max;
      r     = p >>> FRAC;
      r_max = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
      if (r > r_max)
         sat_mag = {1'b0, {(WIDTH-1){1'b1}}};
      else if (r < 0)
         sat_mag = '0;
      else
         sat_mag = r[WIDTH-1:0];
   endfunction

   // Both operands widened to the full product width so the multiply is exact.
   assign x_ext = {{33{x_q[XW-1]}}, x_q};
   assign k_ext = {{XW{1'b0}}, KINV};
   assign prod  = x_ext * k_ext;

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      x_d     = x_q;
      y_d     = y_q;
      mag_d   = mag_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_d     = {{2{in_c[WIDTH-1]}}, in_c};
               y_d     = {{2{in_s[WIDTH-1]}}, in_s};
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            // Rotate left-half-plane vectors by 180 deg so CORDIC converges.
            if (x_q[XW-1]) begin
               x_d = -x_q;
               y_d = -y_q;
            end
            i_d     = '0;
            state_d = S_ROT;
         end
         S_ROT: begin
            // Drive y toward zero; x accumulates K * magnitude.
            if (!y_q[XW-1]) begin
               x_d = x_q + (y_q >>> i_q);
               y_d = y_q - (x_q >>> i_q);
            end else begin
               x_d = x_q - (y_q >>> i_q);
               y_d = y_q + (x_q >>> i_q);
            end
            i_d = i_q + IW'(1);
            if (i_q == IW'(ITER - 1))
               state_d = S_SCALE;
         end
         S_SCALE: begin
            mag_d   = sat_mag(prod);
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         mag_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         mag_q   <= mag_d;
      end
   end

   // CORDIC working registers carry no reset; IDLE always reloads them.
   always_ff @(posedge clk) begin
      x_q <= x_d;
      y_q <= y_d;
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_mag   = mag_q;

endmodule
